// File: rtl/sfx_channel.sv
// rtl/sfx_channel.sv - one-shot/looping sound-effect playback channel for the audio mixer
// Optional feature: define SFX_VOLUME_EN to add a 2-bit volume input that
// right-shifts each fetched sample by (3 - volume).
module sfx_channel #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int CLK_DIV    = 2273
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trigger,
  input  logic                  loop,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] length,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [WIDTH-1:0]      rom_data,
  output logic [WIDTH-1:0]      sample,
  output logic                  busy
`ifdef SFX_VOLUME_EN
  ,
  input  logic [1:0]            volume
`endif
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, PLAY, DRAIN} state_t;

  state_t                state, state_nx;
  logic [DIV_W-1:0]      div, div_nx;
  logic                  trig_q;
  logic [ADDR_WIDTH-1:0] base, base_nx;
  logic [ADDR_WIDTH-1:0] len, len_nx;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nx;
  logic [ADDR_WIDTH-1:0] rom_addr_nx;
  logic [WIDTH-1:0]      sample_nx;
  logic                  busy_nx;

  logic                  tick;
  logic                  start;
  logic [ADDR_WIDTH:0]   cnt_inc;
  logic                  last_smp;
  logic                  rearm;
  logic [WIDTH-1:0]      scaled;

  assign tick     = (div == DIV_W'(CLK_DIV - 1));
  assign start    = trigger & ~trig_q & (length != '0);
  // One extra bit so a full 2^ADDR_WIDTH-1 length cannot wrap the compare
  assign cnt_inc  = {1'b0, cnt} + {{ADDR_WIDTH{1'b0}}, 1'b1};
  assign last_smp = (cnt_inc >= {1'b0, len});
  assign rearm    = loop & trigger;

`ifdef SFX_VOLUME_EN
  assign scaled = rom_data >> (2'd3 - volume);
`else
  assign scaled = rom_data;
`endif

  // State and datapath registers; reset silences the channel immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      div      <= '0;
      trig_q   <= 1'b0;
      base     <= '0;
      len      <= '0;
      cnt      <= '0;
      rom_addr <= '0;
      sample   <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      div      <= div_nx;
      trig_q   <= trigger;
      base     <= base_nx;
      len      <= len_nx;
      cnt      <= cnt_nx;
      rom_addr <= rom_addr_nx;
      sample   <= sample_nx;
      busy     <= busy_nx;
    end
  end

  // Next state: a start always wins, otherwise advance only on sample ticks
  always_comb begin
    state_nx = state;
    if (start) begin
      state_nx = PLAY;
    end else if (tick) begin
      case (state)
        PLAY:    if (last_smp && !rearm) state_nx = DRAIN;
        DRAIN:   state_nx = IDLE;
        default: state_nx = state;
      endcase
    end
  end

  // Datapath next values: divider, address walk, sample load and drain
  always_comb begin
    div_nx      = tick ? '0 : div + DIV_W'(1);
    base_nx     = base;
    len_nx      = len;
    cnt_nx      = cnt;
    rom_addr_nx = rom_addr;
    sample_nx   = sample;
    busy_nx     = busy;
    if (start) begin
      div_nx      = '0;
      base_nx     = start_addr;
      len_nx      = length;
      rom_addr_nx = start_addr;
      cnt_nx      = '0;
      busy_nx     = 1'b1;
    end else if (tick) begin
      case (state)
        PLAY: begin
          sample_nx = scaled;
          cnt_nx    = cnt_inc[ADDR_WIDTH-1:0];
          if (!last_smp) begin
            rom_addr_nx = rom_addr + ADDR_WIDTH'(1);
          end else if (rearm) begin
            rom_addr_nx = base;
            cnt_nx      = '0;
          end
        end
        DRAIN: begin
          sample_nx = '0;
          busy_nx   = 1'b0;
        end
        default: begin
          sample_nx = sample;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sfx_channel.sv
// tb/tb_sfx_channel.sv - self-checking bench for sfx_channel with a cycle-offset playback model
module tb_sfx_channel;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trigger = 1'b0;
  logic        loop = 1'b0;
  logic [11:0] start_addr = 12'h000;
  logic [11:0] length = 12'h000;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data = 8'h00;
  logic [7:0]  sample;
  logic        busy;
  logic [1:0]  vol = 2'd3;
`ifdef SFX_VOLUME_EN
  logic [1:0]  volume;
  assign volume = vol;
`endif

  int passed = 0;
  int total  = 0;

  sfx_channel #(.WIDTH(8), .ADDR_WIDTH(12), .CLK_DIV(D)) dut (
    .clk(clk),
    .rst(rst),
    .trigger(trigger),
    .loop(loop),
    .start_addr(start_addr),
    .length(length),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .sample(sample),
    .busy(busy)
`ifdef SFX_VOLUME_EN
    ,
    .volume(volume)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous ROM: ROM[a] = a[7:0] + 1, one cycle latency
  always @(posedge clk) rom_data <= rom_addr[7:0] + 8'd1;

  function automatic logic [7:0] samp(input logic [11:0] a);
    logic [7:0] v;
    v = a[7:0] + 8'd1;
`ifdef SFX_VOLUME_EN
    v = v >> (2'd3 - vol);
`endif
    return v;
  endfunction

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick_step();
    @(posedge clk);
    #1;
  endtask

  // Single-pulse, non-loop clip; k counts edges from the start edge E0 (k=0)
  task automatic run_clip(input logic [11:0] s, input logic [11:0] l);
    int endk;
    int idx;
    logic [11:0] a;
    endk = (int'(l) + 1) * D;
    start_addr = s;
    length = l;
    loop = 1'b0;
    trigger = 1'b1;
    for (int k = 0; k <= endk + 1; k++) begin
      tick_step();
      if (k == 0) trigger = 1'b0;
      a = s + 12'(k / D - 1);
      chk("clip_sample", {4'h0, sample}, (k < D || k >= endk) ? 12'h000 : {4'h0, samp(a)});
      chk("clip_busy", {11'h0, busy}, {11'h0, k < endk});
      idx = (k / D < int'(l) - 1) ? k / D : int'(l) - 1;
      chk("clip_addr", rom_addr, s + 12'(idx));
    end
  endtask

  initial begin
    logic [11:0] rs;
    logic [11:0] rl;

    // Reset state
    #2;
    chk("rst_sample", {4'h0, sample}, 12'h000);
    chk("rst_busy", {11'h0, busy}, 12'h000);
    chk("rst_addr", rom_addr, 12'h000);
    tick_step();
    rst = 1'b0;
    repeat (3) tick_step();

    // Basic clip: 0x11, 0x12, 0x13 then silence at +16
    run_clip(12'h010, 12'd3);
    repeat (2) tick_step();

    // Address wrap at top of ROM: 0xFFF then 0x000
    run_clip(12'hFFF, 12'd2);
    repeat (3) tick_step();

    // Loop held for 20 edges: two seamless passes then drain
    start_addr = 12'h010;
    length = 12'd3;
    loop = 1'b1;
    trigger = 1'b1;
    for (int k = 0; k <= 30; k++) begin
      tick_step();
      if (k == 19) trigger = 1'b0;
      chk("loop_sample", {4'h0, sample},
          (k < 4 || k >= 28) ? 12'h000 : {4'h0, samp(12'h010 + 12'((k / 4 - 1) % 3))});
      chk("loop_busy", {11'h0, busy}, {11'h0, k < 28});
    end
    loop = 1'b0;
    repeat (2) tick_step();

    // Retrigger 6 edges after first start
    start_addr = 12'h010;
    length = 12'd3;
    trigger = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      tick_step();
      if (k == 0) trigger = 1'b0;
      chk("retrig_a_sample", {4'h0, sample}, (k < 4) ? 12'h000 : {4'h0, samp(12'h010)});
    end
    trigger = 1'b1;
    for (int j = 0; j <= 17; j++) begin
      tick_step();
      if (j == 0) trigger = 1'b0;
      chk("retrig_b_sample", {4'h0, sample},
          (j < 4) ? {4'h0, samp(12'h010)} :
          (j < 16) ? {4'h0, samp(12'h010 + 12'(j / 4 - 1))} : 12'h000);
      chk("retrig_b_busy", {11'h0, busy}, {11'h0, j < 16});
    end
    repeat (2) tick_step();

    // length = 0 is ignored
    start_addr = 12'h123;
    length = 12'd0;
    trigger = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick_step();
      chk("len0_busy", {11'h0, busy}, 12'h000);
      chk("len0_sample", {4'h0, sample}, 12'h000);
    end
    trigger = 1'b0;
    repeat (2) tick_step();

    // Asynchronous reset mid-PLAY silences output before the next edge
    start_addr = 12'h010;
    length = 12'd3;
    trigger = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick_step();
      trigger = 1'b0;
    end
    chk("prerst_sample", {4'h0, sample}, {4'h0, samp(12'h010)});
    chk("prerst_busy", {11'h0, busy}, 12'h001);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_sample", {4'h0, sample}, 12'h000);
    chk("async_rst_busy", {11'h0, busy}, 12'h000);
    chk("async_rst_addr", rom_addr, 12'h000);
    tick_step();
    rst = 1'b0;
    repeat (2) tick_step();

`ifdef SFX_VOLUME_EN
    // Volume 1: samples scaled by 1/4
    vol = 2'd1;
    run_clip(12'h010, 12'd3);
    vol = 2'd3;
    repeat (2) tick_step();
`endif

    // Randomized clips against the model
    for (int n = 0; n < 8; n++) begin
      rs = 12'($urandom_range(0, 4095));
      rl = 12'($urandom_range(1, 5));
      if (n == 0) rs = 12'hFFD;
      run_clip(rs, rl);
      repeat ($urandom_range(1, 4)) tick_step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sfx_channel.md
# sfx_channel

One sound-effect playback channel that feeds one unsigned `WIDTH`-bit input of the 8-channel audio mixer. On a rising edge of its trigger bit (a game sound-port bit), it streams `length` samples from a synchronous sample ROM, starting at `start_addr`, at a fixed sample rate derived from the system clock. Loop mode repeats the clip while the trigger is held (UFO drone style). One instance per effect; all instances share the mixer's sample format: unsigned, silence = 0.

## Interface
- `WIDTH`, 8: sample width; equals the mixer channel width.
- `ADDR_WIDTH`, 12: sample ROM address width.
- `CLK_DIV`, 2273: system clocks per output sample; must be ≥ 2.
- `clk` in 1: system clock, rising-edge.
- `rst` in 1: reset, asynchronous, active-high.
- `trigger` in 1: play request, level; a rising edge starts playback.
- `loop` in 1: 1 = repeat the clip while `trigger` is high.
- `start_addr` in `ADDR_WIDTH`: first ROM address of the clip; latched at start.
- `length` in `ADDR_WIDTH`: samples per pass; latched at start; 0 = effect disabled.
- `rom_addr` out `ADDR_WIDTH`: ROM address, registered.
- `rom_data` in `WIDTH`: ROM data for `rom_addr`, valid 1 cycle after the address.
- `sample` out `WIDTH`: channel output to the mixer, registered.
- `busy` out 1: clip in progress, registered.

## Operation
- States: IDLE, PLAY, DRAIN.
- Divider:
  - Counter `div` runs 0..CLK_DIV-1; `tick` = (`div` == CLK_DIV-1).
  - Any start forces `div` to 0.
- Edge detect: `trig_q` registers `trigger`; `start` = `trigger & ~trig_q & (length != 0)`.
- `start`, accepted in any state, so a retrigger restarts the clip:
  - latch `start_addr` and `length`; `rom_addr` ← `start_addr`; `cnt` ← 0; `busy` ← 1; go to PLAY.
  - `sample` is unchanged by the start itself.
- PLAY on `tick`:
  - `sample` ← `rom_data`; `cnt` ← `cnt`+1.
  - If `cnt`+1 < latched length: `rom_addr` ← `rom_addr`+1. The address wraps modulo 2^ADDR_WIDTH.
  - Else, with `loop & trigger`: `rom_addr` ← latched start, `cnt` ← 0, stay in PLAY. The loop is seamless with no gap sample.
  - Else go to DRAIN, `rom_addr` held.
- DRAIN on `tick`: `sample` ← 0, `busy` ← 0, go to IDLE. The last sample is therefore held for one full sample period.
- IDLE: `sample` = 0, `busy` = 0; `tick` has no effect.
- Trigger release:
  - Non-loop clip: plays to completion.
  - Loop clip: finishes the current pass, then drains.
- Simultaneous `start` and `tick`: `start` wins and the tick is discarded.
- `length` = 0 at a trigger edge: ignored, state unchanged.

## Timing
- Reset values: `sample` = 0, `busy` = 0, `rom_addr` = 0, `div` = 0, `trig_q` = 0, state IDLE.
- Reset mid-clip returns to IDLE at once; the output goes silent asynchronously.
- `busy` rises 1 cycle after the `trigger` edge appears at a clock edge.
- First sample timing: `rom_addr` = start on edge E0; `sample` = ROM[start] on edge E0+CLK_DIV. Because CLK_DIV ≥ 2, ROM data is always valid.
- After the first sample, `sample` changes only on tick edges, exactly CLK_DIV cycles apart.
- Non-loop clip: `busy` falls and `sample` goes to 0 at edge E0+(length+1)·CLK_DIV.

## Configuration
- `SFX_VOLUME_EN` defined:
  - Adds input port `volume` [1:0].
  - The value loaded into `sample` is `rom_data >> (3 - volume)`; volume 3 = full scale, 0 = 1/8.
  - `volume` is sampled at each tick, not latched.
- `SFX_VOLUME_EN` undefined: no `volume` port; `sample` takes `rom_data` unscaled.

## Test plan
- Conditions for all scenarios: CLK_DIV=4; ROM[a] = a[7:0]+1; start_addr=0x010; length=3.
- Basic: one `trigger` pulse, loop=0.
  - `sample` = 0x11, 0x12, 0x13, each held 4 cycles, first at 4 cycles after the start edge.
  - `sample` = 0 and `busy` = 0 at 16 cycles after the start edge.
- Loop: loop=1, trigger held for 20 cycles.
  - Samples 0x11, 0x12, 0x13, 0x11, 0x12, 0x13 with no gap, then 0 and `busy` low.
- Retrigger: second rising edge 6 cycles after the first.
  - Sequence restarts: 0x11 appears 4 cycles after the second edge.
  - 0x13 is never reached before the restart.
- Edge cases:
  - length=0 with a trigger: `busy` stays 0, `sample` stays 0.
  - start_addr=0xFFF, length=2: `rom_addr` goes 0xFFF then 0x000; samples 0x00 then 0x01.
- Reset asserted mid-PLAY, asynchronously between clock edges: `sample` = 0 and `busy` = 0 immediately, before the next clock edge.
- With `SFX_VOLUME_EN`, volume=1: samples 0x04, 0x04, 0x04, i.e. 0x11..0x13 >> 2.
